// File: rtl/abh_pkg.sv
// Shared encodings for the address-bus-high stage: base/offset selects and fixup FSM states.
package abh_pkg;

  localparam logic [1:0] BASE_ZERO = 2'b00;
  localparam logic [1:0] BASE_PCH  = 2'b01;
  localparam logic [1:0] BASE_AHH  = 2'b10;
  localparam logic [1:0] BASE_DB   = 2'b11;

  localparam logic [1:0] OFS_NONE   = 2'b00;
  localparam logic [1:0] OFS_CI     = 2'b01;
  localparam logic [1:0] OFS_BRANCH = 2'b10;
  localparam logic [1:0] OFS_STACK  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } abh_state_e;

  // A deferred carry only needs a fixup cycle when the low byte actually carried.
  function automatic logic fix_request(input logic defer, input logic [1:0] ofs, input logic ci);
    return defer && (ofs == OFS_CI) && ci;
  endfunction

endpackage

// File: rtl/abh_fix.sv
// Page-cross fixup sequencer: one rdy-qualified FIX cycle that forces ADH to ABH+1.
module abh_fix
  import abh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy_i,
  input  logic       defer_i,
  input  logic [1:0] ofs_i,
  input  logic       ci_i,
  input  logic [7:0] abh_i,
  input  logic [7:0] adh_norm_i,
  output logic       fix_o,
  output logic [7:0] adh_o
);

  abh_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rdy_i && fix_request(defer_i, ofs_i, ci_i)) state_d = ST_FIX;
      // Requests seen while fixing are dropped, so FIX never runs back to back.
      ST_FIX:  if (rdy_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign fix_o = (state_q == ST_FIX);
  assign adh_o = fix_o ? (abh_i + 8'd1) : adh_norm_i;

endmodule

// File: rtl/abh.sv
// Address Bus High stage: base mux and high-byte adder feeding ADH, plus PCH/AHH/ABH registers.
module abh
  import abh_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] RESET_PCH  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       CI,
  input  logic       pcl_co,
  input  logic [7:0] DB,
  input  logic [3:0] op,
  input  logic       bsign,
  input  logic       defer,
  input  logic       ld_ahh,
  input  logic       ld_pc,
  output logic       fix,
  output logic [7:0] PCH,
  output logic [7:0] ADH
);

  logic [7:0] pch_q, pch_d;
  logic [7:0] ahh_q, ahh_d;
  logic [7:0] abh_q, abh_d;
  logic [7:0] base;
  logic [7:0] adh_norm;
  logic [1:0] base_sel;
  logic [1:0] ofs_sel;

  assign base_sel = op[3:2];
  assign ofs_sel  = op[1:0];

  always_comb begin
    base = 8'h00;
    case (base_sel)
      BASE_ZERO: base = 8'h00;
      BASE_PCH:  base = pch_q;
      BASE_AHH:  base = ahh_q;
      BASE_DB:   base = DB;
      default:   base = 8'h00;
    endcase
  end

  // Branch adds the sign-extended offset sign: forward +CI, backward -1+CI.
  always_comb begin
    adh_norm = base;
    case (ofs_sel)
      OFS_NONE:   adh_norm = base;
      OFS_CI:     adh_norm = base + {7'b0, CI & ~defer};
      OFS_BRANCH: adh_norm = abh_q + {8{bsign}} + {7'b0, CI};
      OFS_STACK:  adh_norm = STACK_PAGE;
      default:    adh_norm = base;
    endcase
  end

  abh_fix u_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy_i      (rdy),
    .defer_i    (defer),
    .ofs_i      (ofs_sel),
    .ci_i       (CI),
    .abh_i      (abh_q),
    .adh_norm_i (adh_norm),
    .fix_o      (fix),
    .adh_o      (ADH)
  );

  always_comb begin
    abh_d = abh_q;
    ahh_d = ahh_q;
    pch_d = pch_q;
    if (rdy) begin
      abh_d = ADH;
      if (ld_ahh) ahh_d = DB;
      // PCH takes the pre-edge ABH, mirroring PCL loading from ABL.
      if (ld_pc)  pch_d = abh_q + {7'b0, pcl_co};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abh_q <= 8'h00;
      ahh_q <= 8'h00;
      pch_q <= RESET_PCH;
    end else begin
      abh_q <= abh_d;
      ahh_q <= ahh_d;
      pch_q <= pch_d;
    end
  end

  assign PCH = pch_q;

endmodule

// File: tb/tb_abh.sv
// Directed bench for abh: cycle model checked every negedge plus hand-computed expectations.
module tb_abh;

  logic       clk = 1'b0;
  logic       rst_n, rdy, CI, pcl_co, bsign, defer, ld_ahh, ld_pc;
  logic [7:0] DB;
  logic [3:0] op;
  logic       fix;
  logic [7:0] PCH, ADH;

  int n_cmp = 0;
  int n_bad = 0;

  // clock/reset
  always #5 clk = ~clk;

  abh dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(CI), .pcl_co(pcl_co), .DB(DB),
    .op(op), .bsign(bsign), .defer(defer), .ld_ahh(ld_ahh), .ld_pc(ld_pc),
    .fix(fix), .PCH(PCH), .ADH(ADH)
  );

  // model: architectural registers as plain integers
  int  m_abh, m_ahh, m_pch;
  bit  m_fix;
  bit  m_valid = 0;

  function automatic int model_adh();
    int b;
    if (m_fix) return (m_abh + 1) % 256;
    case (op[3:2])
      2'd0: b = 0;
      2'd1: b = m_pch;
      2'd2: b = m_ahh;
      default: b = int'(DB);
    endcase
    case (op[1:0])
      2'd0: return b;
      2'd1: return defer ? b : (b + int'(CI)) % 256;
      2'd2: return (m_abh + (bsign ? 255 : 0) + int'(CI)) % 256;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) begin
    int nadh;
    bit nfix;
    if (!rst_n) begin
      m_abh = 0; m_ahh = 0; m_pch = 0; m_fix = 0; m_valid = 1;
    end else if (rdy && m_valid) begin
      nadh = model_adh();
      nfix = !m_fix && defer && (op[1:0] == 2'd1) && CI;
      if (ld_pc)  m_pch = (m_abh + int'(pcl_co)) % 256;
      if (ld_ahh) m_ahh = int'(DB);
      m_abh = nadh;
      m_fix = nfix;
    end
  end

  // scoreboard: expected output vector pushed and popped each compared cycle
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    logic [16:0] e;
    if (m_valid) begin
      exp_q.push_back({m_fix, 8'(m_pch), 8'(model_adh())});
      e = exp_q.pop_front();
      n_cmp++;
      if ({fix, PCH, ADH} !== e) begin
        n_bad++;
        $display("FAIL model t=%0t fix/PCH/ADH got %b/%h/%h expected %b/%h/%h",
                 $time, fix, PCH, ADH, e[16], e[15:8], e[7:0]);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    CI = 0; pcl_co = 0; bsign = 0; defer = 0; ld_ahh = 0; ld_pc = 0;
    DB = 8'h00; op = 4'b0000; rdy = 1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0; rdy = 0;
    tick();
    rst_n = 1; rdy = 1;
    settle();
    lit("reset_fix", {7'b0, fix}, 8'h00);
    lit("reset_pch", PCH, 8'h00);
    op = 4'b0010; settle();
    lit("reset_abh", ADH, 8'h00);

    // load PCH=12 through ABH
    op = 4'b1100; DB = 8'h12; tick();
    idle_inputs(); ld_pc = 1; tick();
    idle_inputs(); settle();
    lit("pch_load", PCH, 8'h12);
    op = 4'b0100; settle();
    lit("adh_pch", ADH, 8'h12);

    // absolute indexed, no page cross
    idle_inputs(); ld_ahh = 1; DB = 8'h20; tick();
    idle_inputs(); op = 4'b1001; defer = 1; CI = 0; settle();
    lit("idx_nocross_adh", ADH, 8'h20);
    tick();
    lit("idx_nocross_fix", {7'b0, fix}, 8'h00);

    // page cross with fixup
    idle_inputs(); op = 4'b1001; defer = 1; CI = 1; settle();
    lit("cross_first_adh", ADH, 8'h20);
    tick();
    idle_inputs(); settle();
    lit("cross_fix", {7'b0, fix}, 8'h01);
    lit("cross_fix_adh", ADH, 8'h21);
    tick();
    lit("cross_exit_fix", {7'b0, fix}, 8'h00);
    lit("cross_exit_adh", ADH, 8'h00);

    // fixup held by rdy; a request during FIX is ignored
    op = 4'b1001; defer = 1; CI = 1; tick();
    idle_inputs(); rdy = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      lit("hold_fix", {7'b0, fix}, 8'h01);
      lit("hold_adh", ADH, 8'h21);
      tick();
    end
    rdy = 1; op = 4'b1001; defer = 1; CI = 1; settle();
    lit("hold_exit_adh", ADH, 8'h21);
    tick();
    idle_inputs(); settle();
    lit("no_back_to_back", {7'b0, fix}, 8'h00);

    // branch
    op = 4'b1100; DB = 8'h05; tick();
    idle_inputs(); op = 4'b0010; bsign = 1; CI = 0; settle();
    lit("branch_back", ADH, 8'h04);
    bsign = 0; CI = 1; settle();
    lit("branch_fwd", ADH, 8'h06);
    idle_inputs(); tick();
    op = 4'b0010; bsign = 1; CI = 0; settle();
    lit("branch_wrap", ADH, 8'hFF);

    // PC increment carry and stack page
    idle_inputs(); op = 4'b1100; DB = 8'h7F; tick();
    idle_inputs(); ld_pc = 1; pcl_co = 1; tick();
    idle_inputs(); settle();
    lit("pch_carry", PCH, 8'h80);
    op = 4'b0011; settle();
    lit("stack_page", ADH, 8'h01);

    // FIX wrap at FF, ld_ahh honoured during FIX
    idle_inputs(); ld_ahh = 1; DB = 8'hFF; tick();
    idle_inputs(); op = 4'b1001; defer = 1; CI = 1; tick();
    idle_inputs(); ld_ahh = 1; DB = 8'h33; op = 4'b0111; CI = 1; settle();
    lit("fix_wrap_adh", ADH, 8'h00);
    tick();
    idle_inputs(); op = 4'b1000; settle();
    lit("ahh_during_fix", ADH, 8'h33);

    // reset during FIX
    op = 4'b1001; defer = 1; CI = 1; tick();
    idle_inputs(); settle();
    lit("pre_reset_fix", {7'b0, fix}, 8'h01);
    rst_n = 0; rdy = 0; tick();
    rst_n = 1; rdy = 1; settle();
    lit("reset_in_fix", {7'b0, fix}, 8'h00);
    lit("reset_in_fix_pch", PCH, 8'h00);
    lit("reset_in_fix_adh", ADH, 8'h00);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
